// File: rtl/hls_chn_in_pkg.sv
// Shared helpers for the multi-channel input wait datapath: counter and
// pointer widths, parameter legality and payload slice offsets.
// Optional feature macro: HLS_CHN_IN_BYPASS_EN (see hls_chn_in_fifo).
package hls_chn_in_pkg;

    localparam int MAX_CHN   = 8;
    localparam int MAX_DEPTH = 16;

    // Ceiling log2 usable in constant expressions.
    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Width of a count that must reach DEPTH inclusive.
    function automatic int cnt_w(input int depth);
        return clog2_f(depth + 1);
    endfunction

    // Width of a pointer into DEPTH entries, never narrower than 1 bit.
    function automatic int ptr_w(input int depth);
        return (depth <= 1) ? 1 : clog2_f(depth);
    endfunction

    function automatic bit params_ok(input int num_chn, input int depth);
        return (num_chn >= 1) && (num_chn <= MAX_CHN) &&
               (depth >= 1) && (depth <= MAX_DEPTH);
    endfunction

    // Low bit of channel idx inside a packed NUM_CHN*width bus.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/hls_chn_in_fifo.sv
// One input channel: DEPTH-entry skid FIFO with count, head/tail pointers,
// ready generation and the operand availability/head mux.
// With HLS_CHN_IN_BYPASS_EN defined an empty FIFO forwards the incoming
// operand in the same cycle; otherwise every operand is registered first.
//
// Handshake: an operand is transferred when vld_i & rdy_o in the same cycle;
// rdy_o depends only on registered state, vld_i is held upstream while
// rdy_o = 0. pop_i consumes the operand shown on pd_o and is only asserted
// by the parent while avail_o = 1.
module hls_chn_in_fifo
    import hls_chn_in_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 2,
    localparam int CNTW  = cnt_w(DEPTH),
    localparam int PTRW  = ptr_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             vld_i,
    output logic             rdy_o,
    input  logic [WIDTH-1:0] pd_i,
    input  logic             pop_i,
    output logic             avail_o,
    output logic [WIDTH-1:0] pd_o,
    output logic [CNTW-1:0]  cnt_o
);

    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [PTRW-1:0]  head_q, head_d;
    logic [PTRW-1:0]  tail_q, tail_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             empty;
    logic             push;
    logic             store;
    logic             deq;

    // Pointers wrap at DEPTH so non-power-of-2 depths work.
    function automatic logic [PTRW-1:0] nxt_ptr(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (cnt_q == '0);
    assign rdy_o = (cnt_q < CNTW'(DEPTH));
    assign push  = vld_i & rdy_o;
    assign cnt_o = cnt_q;

`ifdef HLS_CHN_IN_BYPASS_EN
    assign avail_o = ~empty | push;
    assign pd_o    = empty ? pd_i : mem_q[head_q];
`else
    assign avail_o = ~empty;
    assign pd_o    = mem_q[head_q];
`endif

    // A push into an empty FIFO that is popped in the same cycle passes
    // straight through and is never stored.
    assign store = push & ~(pop_i & empty);
    assign deq   = pop_i & ~empty;

    // Next-state for count and pointers.
    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        if (store) tail_d = nxt_ptr(tail_q);
        if (deq)   head_d = nxt_ptr(head_q);
        case ({store, deq})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State and storage registers; reset voids any in-flight push/pop.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
            if (store) mem_q[tail_q] <= pd_i;
        end
    end

endmodule

// File: rtl/hls_chn_in_wait_dp_mc.sv
// Multi-channel input wait datapath: NUM_CHN skid FIFOs joined into one
// operand set for the core. The set is available only when every channel
// has an operand; a core consume pops all channels together.
// Optional feature macro: HLS_CHN_IN_BYPASS_EN (zero-latency pass-through).
module hls_chn_in_wait_dp_mc
    import hls_chn_in_pkg::*;
#(
    parameter  int NUM_CHN = 2,
    parameter  int WIDTH   = 16,
    parameter  int DEPTH   = 2,
    localparam int CNTW    = cnt_w(DEPTH)
) (
    input  logic                     nvdla_core_clk,
    input  logic                     nvdla_core_rstn,
    input  logic [NUM_CHN-1:0]       chn_in_vld,
    output logic [NUM_CHN-1:0]       chn_in_rdy,
    input  logic [NUM_CHN*WIDTH-1:0] chn_in_pd,
    input  logic                     core_oswt,
    input  logic                     core_bdwt,
    output logic                     core_bawt,
    output logic                     core_wen_comp,
    output logic [NUM_CHN*WIDTH-1:0] core_pd_mxwt,
    output logic [NUM_CHN*CNTW-1:0]  chn_cnt
);

    if (!params_ok(NUM_CHN, DEPTH)) begin : g_param_err
        $error("hls_chn_in_wait_dp_mc: NUM_CHN must be 1..8 and DEPTH 1..16");
    end

    logic [NUM_CHN-1:0] avail;
    logic               pop;

    // Join: the core may only consume when every channel can supply.
    assign core_bawt     = &avail;
    assign pop           = core_bdwt & core_bawt;
    assign core_wen_comp = ~core_oswt | core_bawt;

    for (genvar i = 0; i < NUM_CHN; i++) begin : g_chn
        hls_chn_in_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk_i   (nvdla_core_clk),
            .rstn_i  (nvdla_core_rstn),
            .vld_i   (chn_in_vld[i]),
            .rdy_o   (chn_in_rdy[i]),
            .pd_i    (chn_in_pd[slice_lo(i, WIDTH) +: WIDTH]),
            .pop_i   (pop),
            .avail_o (avail[i]),
            .pd_o    (core_pd_mxwt[slice_lo(i, WIDTH) +: WIDTH]),
            .cnt_o   (chn_cnt[slice_lo(i, CNTW) +: CNTW])
        );
    end

endmodule

// File: tb/tb_hls_chn_in_wait_dp_mc.sv
// Directed bench for hls_chn_in_wait_dp_mc. Two instances share clock and
// reset: a DEPTH=2 instance for join/fill/drain/reset scenarios and a
// DEPTH=3 instance for pointer wrap. Expected values follow the build
// selected by HLS_CHN_IN_BYPASS_EN.
module tb_hls_chn_in_wait_dp_mc;

`ifdef HLS_CHN_IN_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rstn;

    logic [1:0]  d2_vld, d2_rdy;
    logic [31:0] d2_pd, d2_mxwt;
    logic        d2_oswt, d2_bdwt, d2_bawt, d2_wen;
    logic [3:0]  d2_cnt;

    logic [1:0]  d3_vld, d3_rdy;
    logic [31:0] d3_pd, d3_mxwt;
    logic        d3_oswt, d3_bdwt, d3_bawt, d3_wen;
    logic [3:0]  d3_cnt;

    logic [31:0] exp_q[$];
    int          n_tests;
    int          n_fail;

    hls_chn_in_wait_dp_mc #(.NUM_CHN(2), .WIDTH(16), .DEPTH(2)) u_d2 (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .chn_in_vld      (d2_vld),
        .chn_in_rdy      (d2_rdy),
        .chn_in_pd       (d2_pd),
        .core_oswt       (d2_oswt),
        .core_bdwt       (d2_bdwt),
        .core_bawt       (d2_bawt),
        .core_wen_comp   (d2_wen),
        .core_pd_mxwt    (d2_mxwt),
        .chn_cnt         (d2_cnt)
    );

    hls_chn_in_wait_dp_mc #(.NUM_CHN(2), .WIDTH(16), .DEPTH(3)) u_d3 (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .chn_in_vld      (d3_vld),
        .chn_in_rdy      (d3_rdy),
        .chn_in_pd       (d3_pd),
        .core_oswt       (d3_oswt),
        .core_bdwt       (d3_bdwt),
        .core_bawt       (d3_bawt),
        .core_wen_comp   (d3_wen),
        .core_pd_mxwt    (d3_mxwt),
        .chn_cnt         (d3_cnt)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        d2_vld = 2'b00; d2_pd = 32'h1234_5678; d2_oswt = 1'b0; d2_bdwt = 1'b0;
        d3_vld = 2'b00; d3_pd = 32'h0;         d3_oswt = 1'b0; d3_bdwt = 1'b0;
        step();
        step();
        n_tests++;
        if (d2_rdy !== 2'b11) begin
            n_fail++; $display("FAIL reset_rdy: got %b want 11", d2_rdy);
        end
        n_tests++;
        if (d2_bawt !== 1'b0) begin
            n_fail++; $display("FAIL reset_bawt: got %b want 0", d2_bawt);
        end
        n_tests++;
        if (d2_cnt !== 4'h0 || d3_cnt !== 4'h0) begin
            n_fail++; $display("FAIL reset_cnt: got %h/%h want 0/0", d2_cnt, d3_cnt);
        end
        n_tests++;
        if (d2_mxwt !== (BYP ? 32'h1234_5678 : 32'h0)) begin
            n_fail++; $display("FAIL reset_mxwt: got %h want %h", d2_mxwt,
                               (BYP ? 32'h1234_5678 : 32'h0));
        end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_join();
        d2_vld = 2'b11; d2_pd = 32'h4000_3C00; d2_oswt = 1'b1; d2_bdwt = 1'b1;
        #1;
`ifdef HLS_CHN_IN_BYPASS_EN
        n_tests++;
        if (d2_bawt !== 1'b1 || d2_wen !== 1'b1) begin
            n_fail++; $display("FAIL join_bawt: got bawt=%b wen=%b want 1/1", d2_bawt, d2_wen);
        end
        n_tests++;
        if (d2_mxwt !== 32'h4000_3C00) begin
            n_fail++; $display("FAIL join_mxwt: got %h want 40003c00", d2_mxwt);
        end
        step();
        d2_vld = 2'b00; d2_bdwt = 1'b0;
        #1;
        n_tests++;
        if (d2_cnt !== 4'h0 || d2_bawt !== 1'b0) begin
            n_fail++; $display("FAIL join_cnt: got cnt=%h bawt=%b want 0/0", d2_cnt, d2_bawt);
        end
`else
        n_tests++;
        if (d2_bawt !== 1'b0 || d2_wen !== 1'b0) begin
            n_fail++; $display("FAIL join_bawt0: got bawt=%b wen=%b want 0/0", d2_bawt, d2_wen);
        end
        step();
        d2_vld = 2'b00;
        #1;
        n_tests++;
        if (d2_cnt !== 4'b0101 || d2_bawt !== 1'b1) begin
            n_fail++; $display("FAIL join_next: got cnt=%h bawt=%b want 5/1", d2_cnt, d2_bawt);
        end
        n_tests++;
        if (d2_mxwt !== 32'h4000_3C00) begin
            n_fail++; $display("FAIL join_mxwt: got %h want 40003c00", d2_mxwt);
        end
        step();
        d2_bdwt = 1'b0;
        #1;
        n_tests++;
        if (d2_cnt !== 4'h0) begin
            n_fail++; $display("FAIL join_pop: got cnt=%h want 0", d2_cnt);
        end
`endif
    endtask

    task automatic test_fill();
        d2_vld = 2'b01; d2_pd = 32'h0000_1111; d2_oswt = 1'b1; d2_bdwt = 1'b0;
        #1;
        n_tests++;
        if (d2_rdy !== 2'b11 || d2_bawt !== 1'b0 || d2_wen !== 1'b0) begin
            n_fail++; $display("FAIL fill_c1: got rdy=%b bawt=%b wen=%b want 11/0/0",
                               d2_rdy, d2_bawt, d2_wen);
        end
        step();
        n_tests++;
        if (d2_cnt !== 4'b0001) begin
            n_fail++; $display("FAIL fill_cnt1: got %h want 1", d2_cnt);
        end
        step();
        n_tests++;
        if (d2_cnt !== 4'b0010 || d2_rdy !== 2'b10) begin
            n_fail++; $display("FAIL fill_full: got cnt=%h rdy=%b want 2/10", d2_cnt, d2_rdy);
        end
        n_tests++;
        if (d2_bawt !== 1'b0 || d2_wen !== 1'b0) begin
            n_fail++; $display("FAIL fill_stall: got bawt=%b wen=%b want 0/0", d2_bawt, d2_wen);
        end
        step();
        n_tests++;
        if (d2_cnt !== 4'b0010) begin
            n_fail++; $display("FAIL fill_hold: got %h want 2", d2_cnt);
        end
    endtask

    task automatic test_ignored_bdwt();
        d2_vld = 2'b00; d2_bdwt = 1'b1; d2_oswt = 1'b0;
        #1;
        n_tests++;
        if (d2_bawt !== 1'b0 || d2_wen !== 1'b1) begin
            n_fail++; $display("FAIL ign_bawt: got bawt=%b wen=%b want 0/1", d2_bawt, d2_wen);
        end
        step();
        n_tests++;
        if (d2_cnt !== 4'b0010) begin
            n_fail++; $display("FAIL ign_cnt: got %h want 2", d2_cnt);
        end
    endtask

    task automatic test_drain();
        d2_vld = 2'b10; d2_pd = 32'h2222_0000; d2_bdwt = 1'b1; d2_oswt = 1'b1;
        #1;
`ifdef HLS_CHN_IN_BYPASS_EN
        n_tests++;
        if (d2_bawt !== 1'b1 || d2_wen !== 1'b1 || d2_mxwt !== 32'h2222_1111) begin
            n_fail++; $display("FAIL drain_pop: got bawt=%b wen=%b mxwt=%h want 1/1/22221111",
                               d2_bawt, d2_wen, d2_mxwt);
        end
        step();
`else
        n_tests++;
        if (d2_bawt !== 1'b0) begin
            n_fail++; $display("FAIL drain_wait: got bawt=%b want 0", d2_bawt);
        end
        step();
        d2_vld = 2'b00;
        #1;
        n_tests++;
        if (d2_cnt !== 4'b0110 || d2_bawt !== 1'b1 || d2_mxwt !== 32'h2222_1111) begin
            n_fail++; $display("FAIL drain_pop: got cnt=%h bawt=%b mxwt=%h want 6/1/22221111",
                               d2_cnt, d2_bawt, d2_mxwt);
        end
        step();
`endif
        d2_vld = 2'b00; d2_bdwt = 1'b0;
        #1;
        n_tests++;
        if (d2_cnt !== 4'b0001 || d2_rdy !== 2'b11) begin
            n_fail++; $display("FAIL drain_after: got cnt=%h rdy=%b want 1/11", d2_cnt, d2_rdy);
        end
    endtask

    task automatic test_reset_mid();
        d2_vld = 2'b01; d2_pd = 32'h0000_3333;
        step();
        n_tests++;
        if (d2_cnt !== 4'b0010 || d2_rdy !== 2'b10) begin
            n_fail++; $display("FAIL rmid_pre: got cnt=%h rdy=%b want 2/10", d2_cnt, d2_rdy);
        end
        rstn = 1'b0; d2_vld = 2'b11; d2_bdwt = 1'b1;
        step();
        rstn = 1'b1; d2_vld = 2'b00; d2_bdwt = 1'b0;
        #1;
        n_tests++;
        if (d2_cnt !== 4'h0 || d2_rdy !== 2'b11 || d2_bawt !== 1'b0) begin
            n_fail++; $display("FAIL rmid_post: got cnt=%h rdy=%b bawt=%b want 0/11/0",
                               d2_cnt, d2_rdy, d2_bawt);
        end
        n_tests++;
        if (d2_mxwt !== (BYP ? 32'h0000_3333 : 32'h0)) begin
            n_fail++; $display("FAIL rmid_mxwt: got %h want %h", d2_mxwt,
                               (BYP ? 32'h0000_3333 : 32'h0));
        end
    endtask

    task automatic test_wrap();
        logic [31:0] v;
        logic        exp_bawt;
        int          pops;
        pops = 0;
        d3_oswt = 1'b1;
        for (int k = 0; k < 5; k++) begin
            v = {16'(16'hB000 + k), 16'(16'hA000 + k)};
            d3_vld = 2'b11; d3_pd = v; d3_bdwt = (k % 2 == 1);
            #1;
            n_tests++;
            if (d3_rdy !== 2'b11) begin
                n_fail++; $display("FAIL wrap_rdy%0d: got %b want 11", k, d3_rdy);
            end
`ifdef HLS_CHN_IN_BYPASS_EN
            exp_q.push_back(v);
            exp_bawt = (exp_q.size() != 0);
`else
            exp_bawt = (exp_q.size() != 0);
            exp_q.push_back(v);
`endif
            n_tests++;
            if (d3_bawt !== exp_bawt || d3_wen !== exp_bawt) begin
                n_fail++; $display("FAIL wrap_bawt%0d: got bawt=%b wen=%b want %b",
                                   k, d3_bawt, d3_wen, exp_bawt);
            end
            if (d3_bdwt && d3_bawt) begin
                n_tests++;
                if (d3_mxwt !== exp_q[0]) begin
                    n_fail++; $display("FAIL wrap_data%0d: got %h want %h", k, d3_mxwt, exp_q[0]);
                end
                void'(exp_q.pop_front());
                pops++;
            end
            step();
        end
        d3_vld = 2'b00; d3_bdwt = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (exp_q.size() == 0) break;
            n_tests++;
            if (d3_bawt !== 1'b1 || d3_mxwt !== exp_q[0]) begin
                n_fail++; $display("FAIL wrap_drain: got bawt=%b mxwt=%h want 1/%h",
                                   d3_bawt, d3_mxwt, exp_q[0]);
            end
            void'(exp_q.pop_front());
            pops++;
            step();
        end
        d3_bdwt = 1'b0;
        #1;
        n_tests++;
        if (pops !== 5 || d3_cnt !== 4'h0 || d3_bawt !== 1'b0) begin
            n_fail++; $display("FAIL wrap_end: got pops=%0d cnt=%h bawt=%b want 5/0/0",
                               pops, d3_cnt, d3_bawt);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_join();
        test_fill();
        test_ignored_bdwt();
        test_drain();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hls_chn_in_wait_dp_mc.md
# hls_chn_in_wait_dp_mc

Multi-channel, parametrised input-side wait datapath for HLS-generated NVDLA cores (fp16/fp32 converters, eltwise ops). Each of NUM_CHN upstream valid/ready channels gets a DEPTH-entry skid FIFO. The core sees one joined operand set that is available only when every channel holds data. This generalises the single-channel, single-entry bcwt/bfwt buffer to N channels, deeper buffering and an optional zero-latency bypass.

## Interface
Parameters:
- NUM_CHN, 2, number of joined input channels (1..8)
- WIDTH, 16, payload bits per channel
- DEPTH, 2, FIFO entries per channel (1..16)

Ports:
- nvdla_core_clk  in  1  sole clock, rising edge
- nvdla_core_rstn  in  1  reset; one clock, reset is synchronous and active-low
- chn_in_vld  in  NUM_CHN  per-channel upstream valid
- chn_in_rdy  out  NUM_CHN  per-channel upstream ready
- chn_in_pd  in  NUM_CHN*WIDTH  payloads, channel i at [i*WIDTH +: WIDTH]
- core_oswt  in  1  core requests operands this cycle
- core_bdwt  in  1  core consumes the joined set this cycle
- core_bawt  out  1  all channels have an operand available
- core_wen_comp  out  1  ~core_oswt | core_bawt (core stall release)
- core_pd_mxwt  out  NUM_CHN*WIDTH  joined operands, same packing as chn_in_pd
- chn_cnt  out  NUM_CHN*CNTW  per-channel stored-entry count, CNTW = clog2(DEPTH+1)

## Operation
- Push[i] = chn_in_vld[i] & chn_in_rdy[i]. chn_in_rdy[i] = (cnt[i] < DEPTH), from registered state only; it has no combinational dependence on core_bdwt.
- avail[i] = (cnt[i] != 0) | push[i] when bypass is compiled in; otherwise avail[i] = (cnt[i] != 0).
- core_bawt = AND of avail[i]. core_wen_comp = ~core_oswt | core_bawt.
- core_pd_mxwt[i] = FIFO head when cnt[i] != 0; otherwise chn_in_pd[i] (bypass build only).
- Pop = core_bdwt & core_bawt. A pop consumes one operand from every channel at once.
- core_bdwt while core_bawt = 0 is ignored: no state change.
- Per channel, with push and pop in the same cycle:
  - cnt = 0: the operand passes straight through, nothing is stored, cnt stays 0 (bypass build only).
  - cnt > 0: write at tail, read at head, cnt unchanged.
- Push without pop: store at tail, cnt+1. Pop without push: advance head, cnt-1.
- Pointers wrap modulo DEPTH, so non-power-of-2 DEPTH is legal.
- A channel at cnt = DEPTH deasserts rdy. Its vld is held off upstream; it is never dropped.
- Channels fill independently. A fast channel may run up to DEPTH ahead of the slowest one.

## Timing
- Reset (nvdla_core_rstn = 0 at a rising edge): cnt, head and tail = 0, storage = 0.
- Outputs during and after reset: chn_in_rdy all 1, core_bawt = 0 until a push, core_pd_mxwt reflects chn_in_pd (bypass build) or 0.
- Reset asserted mid-operation discards all buffered operands at that edge. The in-flight push and pop are both void.
- Latency, bypass build: input to core visibility 0 cycles when cnt = 0, else behind the queued entries.
- Latency, no-bypass build: minimum 1 cycle.
- Throughput: 1 joined set per cycle when all channels stream.
- The core's bawt/wen_comp paths are combinational from vld (bypass build) and from registers (no-bypass build).

## Configuration
- HLS_CHN_IN_BYPASS_EN defined: empty-FIFO pass-through as above. This matches the legacy biwt | bcwt behaviour.
- HLS_CHN_IN_BYPASS_EN undefined: every operand is registered before use. avail depends only on cnt, there is no input-to-core combinational path, and core_pd_mxwt is always the FIFO head.

## Structure
- Package hls_chn_in_pkg holds:
  - CNTW/PTRW helper function (clog2)
  - parameter legality checks (NUM_CHN 1..8, DEPTH 1..16)
  - slice-index helper for packed payloads
- Sub-module hls_chn_in_fifo: one channel with cnt/head/tail, storage, rdy, avail and the head/bypass mux. It is instantiated NUM_CHN times in a generate loop.
- The top level holds only the AND-join, pop generation and wen_comp.

## Test plan
- Reset, then NUM_CHN=2, DEPTH=2, bypass build. Both vld=1 with pd 0x3C00/0x4000, core_oswt=1, core_bdwt=1 -> same cycle: core_bawt=1, mxwt={0x4000,0x3C00}, cnt stays 0,0.
- Only ch0 pushes 0x1111 three cycles, no pop -> cnt0 = 1 then 2, rdy0=0 on the third cycle, core_bawt=0, core_wen_comp=0 with oswt=1.
- From the previous state, ch1 pushes 0x2222 with bdwt=1 -> pop yields {0x2222,0x1111}, cnt0=1, rdy0=1 next cycle.
- DEPTH=3: push 5 values, popping every other cycle -> pointers wrap, FIFO order preserved, no loss or duplication.
- core_bdwt=1 with core_bawt=0 -> no cnt change. Reset asserted with cnt=2 -> next cycle cnt=0, rdy=1.
- No-bypass build, same stimulus as the first scenario -> core_bawt=0 in the push cycle, 1 in the next cycle with the same data.
